// File: rtl/bus_register_bank.sv
// Parametrised general-purpose register bank on the tri-state CPU main bus, with
// +1/-1 stepping and two ALU read ports. Optional macro REGBANK_BYPASS_EN forwards pending writes to the read ports.

module bus_register_bank_cell #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              st,
    input  logic              up,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] nxt
);
    // Load has priority over step; the caller already masks a step that collides with a load.
    always_comb begin
        nxt = q;
        if (rst)
            nxt = '0;
        else if (ld)
            nxt = d;
        else if (st)
            nxt = up ? q + DATA_W'(1) : q - DATA_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= nxt;
    end
endmodule

module bus_register_bank #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int SEL_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] main_bus,
    input  logic              load,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic              out_en,
    input  logic [SEL_W-1:0]  out_sel,
    input  logic              inc,
    input  logic              dec,
    input  logic [SEL_W-1:0]  step_sel,
    input  logic [SEL_W-1:0]  alu_a_sel,
    input  logic [SEL_W-1:0]  alu_b_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              wrap
);
    logic [NREGS-1:0][DATA_W-1:0] q, nxt;
    logic [NREGS-1:0]             ld_hit, st_hit;
    logic                         load_ok, step_act, step_eff, wrap_d;
    logic [DATA_W-1:0]            step_cur;

    function automatic logic in_range(input logic [SEL_W-1:0] s);
        return 32'(s) < NREGS;
    endfunction

    // Out-of-range selects fall through the loop and read as 0.
    function automatic logic [DATA_W-1:0] pick(input logic [NREGS-1:0][DATA_W-1:0] arr,
                                               input logic [SEL_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NREGS; i++)
            if (s == SEL_W'(i)) r = arr[i];
        return r;
    endfunction

    assign load_ok  = load && in_range(load_sel);
    assign step_act = (inc ^ dec) && in_range(step_sel);
    assign step_eff = step_act && !(load_ok && (load_sel == step_sel));
    assign step_cur = pick(q, step_sel);
    assign wrap_d   = step_eff && (inc ? (&step_cur) : ~(|step_cur));

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        assign ld_hit[g] = load_ok  && (load_sel == SEL_W'(g));
        assign st_hit[g] = step_eff && (step_sel == SEL_W'(g));

        bus_register_bank_cell #(.DATA_W(DATA_W)) u_cell (
            .clk (clk),
            .rst (rst),
            .ld  (ld_hit[g]),
            .st  (st_hit[g]),
            .up  (inc),
            .d   (main_bus),
            .q   (q[g]),
            .nxt (nxt[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= wrap_d;
    end

    assign main_bus = out_en ? pick(q, out_sel) : {DATA_W{1'bz}};

`ifdef REGBANK_BYPASS_EN
    assign alu_a = pick(nxt, alu_a_sel);
    assign alu_b = pick(nxt, alu_b_sel);
`else
    assign alu_a = pick(q, alu_a_sel);
    assign alu_b = pick(q, alu_b_sel);
`endif
endmodule
